// File: rtl/fpu_tb_pkg.sv
// Shared definitions for the ROM vector sequencer: FSM state encoding and default widths.
package fpu_tb_pkg;

    localparam int unsigned DEF_W           = 32;
    localparam int unsigned DEF_ADDR_W      = 10;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT_RES = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_LOAD     = S_LOAD,
        ST_ISSUE    = S_ISSUE,
        ST_WAIT_RES = S_WAIT_RES,
        ST_DONE     = S_DONE
    } seq_state_e;

endpackage

// File: rtl/watchdog_counter.sv
// Cycle counter for the result wait; tc_c flags the last allowed cycle (count == TIMEOUT_CYC-1).
module watchdog_counter
    import fpu_tb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at the terminal value so a stale count never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !tc_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == TC_VAL);

endmodule

// File: rtl/rom_vector_sequencer.sv
// Walks the test-vector ROM, hands each word to the DUT and waits for its result with a watchdog.
// Optional result signature register enabled by RESULT_CHECKSUM_EN.
module rom_vector_sequencer
    import fpu_tb_pkg::*;
#(
    parameter int unsigned W           = DEF_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned NUM_VECTORS = 1024,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [W-1:0]      rom_data,
    output logic [W-1:0]      op_data,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic              res_valid,
    input  logic [W-1:0]      result,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [ADDR_W:0]   vec_count,
    output logic [W-1:0]      checksum
);

    localparam int unsigned VCNT_W = ADDR_W + 1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [W-1:0]      op_data_q, op_data_d;
    logic              op_valid_q, op_valid_d;
    logic [VCNT_W-1:0] vec_count_q, vec_count_d;
    logic              timeout_err_q, timeout_err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic run_start_c;
    logic issue_fire_c;
    logic res_accept_c;
    logic last_vec_c;
    logic wd_clear_c;
    logic wd_enable_c;
    logic wd_tc_c;

    // Handshake qualifiers: inputs only count in the state that owns them.
    assign run_start_c  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign issue_fire_c = (state_q == ST_ISSUE) && op_valid_q && op_ready;
    assign res_accept_c = (state_q == ST_WAIT_RES) && res_valid;
    assign last_vec_c   = (vec_count_q + VCNT_W'(1)) == VCNT_W'(NUM_VECTORS);
    assign wd_clear_c   = issue_fire_c;
    assign wd_enable_c  = (state_q == ST_WAIT_RES) && !res_valid;

    watchdog_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear_c),
        .enable (wd_enable_c),
        .tc_c   (wd_tc_c)
    );

    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        op_data_d     = op_data_q;
        op_valid_d    = op_valid_q;
        vec_count_d   = vec_count_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (run_start_c) begin
                    rom_addr_d    = ADDR_W'(START_ADDR);
                    vec_count_d   = '0;
                    timeout_err_d = 1'b0;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                op_data_d  = rom_data;
                op_valid_d = 1'b1;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (issue_fire_c) begin
                    op_valid_d = 1'b0;
                    state_d    = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                // A result arriving on the watchdog's last cycle takes priority.
                if (res_accept_c) begin
                    vec_count_d = vec_count_q + VCNT_W'(1);
                    if (last_vec_c) begin
                        state_d = ST_DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = ST_LOAD;
                    end
                end else if (wd_tc_c) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_ISSUE) || (state_d == ST_WAIT_RES);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            rom_addr_q    <= ADDR_W'(START_ADDR);
            op_data_q     <= '0;
            op_valid_q    <= 1'b0;
            vec_count_q   <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            op_data_q     <= op_data_d;
            op_valid_q    <= op_valid_d;
            vec_count_q   <= vec_count_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign op_data     = op_data_q;
    assign op_valid    = op_valid_q;
    assign vec_count   = vec_count_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef RESULT_CHECKSUM_EN
    logic [W-1:0] checksum_q, checksum_d;

    // Rotate-left-by-one then xor in each accepted result.
    always_comb begin
        checksum_d = checksum_q;
        if (run_start_c) begin
            checksum_d = '0;
        end else if (res_accept_c) begin
            checksum_d = {checksum_q[W-2:0], checksum_q[W-1]} ^ result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_result_c;
    assign unused_result_c = ^result;
    assign checksum        = '0;
`endif

endmodule
